// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: counts APU-rate enables and issues quarter/half-frame
// strobes on a 4-step or 5-step schedule, plus the frame interrupt flag.
// Frame-counter register writes are staged and take effect on the next ce.
module apu_frame_sequencer #(
  parameter int STEP1 = 3728,
  parameter int STEP2 = 7456,
  parameter int STEP3 = 11185,
  parameter int STEP4 = 14914,
  parameter int STEP5 = 18640,
  parameter int CNTW  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       cfg_wr,
  input  logic       cfg_mode5,
  input  logic       cfg_irq_inhibit,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic [2:0] step
);

  // State index is the index of the next event to fire.
  typedef enum logic [2:0] {S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3, S4 = 3'd4} state_t;

  state_t            step_reg, step_next;
  logic [CNTW-1:0]   cnt_reg, cnt_next;
  logic [CNTW-1:0]   target;
  logic              mode5_reg, mode5_next;
  logic              inhibit_reg, inhibit_next;
  logic              pending_reg, pending_next;
  logic              p_mode5_reg, p_mode5_next;
  logic              p_inhibit_reg, p_inhibit_next;
  logic              qf_reg, qf_next;
  logic              hf_reg, hf_next;
  logic              irq_reg, irq_next;
  logic              apply;
  logic              count_en;
  logic              match;
  logic              irq_set;

  // Event threshold for the step the FSM is waiting on.
  always_comb begin
    target = CNTW'(STEP5);
    case (step_reg)
      S0:      target = CNTW'(STEP1);
      S1:      target = CNTW'(STEP2);
      S2:      target = CNTW'(STEP3);
      S3:      target = CNTW'(STEP4);
      default: target = CNTW'(STEP5);
    endcase
  end

  // A write arriving on a ce cycle counts as pending already, so that ce
  // neither counts nor matches; the write is applied on the following ce.
  assign apply    = ce && pending_reg;
  assign count_en = ce && !pending_reg && !cfg_wr;
  assign match    = (cnt_reg == target);

  // Next-state: pending write staging, write apply, counting and step events.
  always_comb begin
    step_next      = step_reg;
    cnt_next       = cnt_reg;
    mode5_next     = mode5_reg;
    inhibit_next   = inhibit_reg;
    pending_next   = pending_reg;
    p_mode5_next   = p_mode5_reg;
    p_inhibit_next = p_inhibit_reg;
    qf_next        = 1'b0;
    hf_next        = 1'b0;
    irq_set        = 1'b0;

    if (cfg_wr) begin
      pending_next   = 1'b1;
      p_mode5_next   = cfg_mode5;
      p_inhibit_next = cfg_irq_inhibit;
    end else if (apply) begin
      pending_next = 1'b0;
    end

    if (apply) begin
      mode5_next   = p_mode5_reg;
      inhibit_next = p_inhibit_reg;
      cnt_next     = '0;
      step_next    = S0;
      // Entering 5-step mode clocks the units once immediately.
      qf_next      = p_mode5_reg;
      hf_next      = p_mode5_reg;
    end else if (count_en) begin
      cnt_next = cnt_reg + CNTW'(1);
      if (match) begin
        case (step_reg)
          S0: begin
            qf_next   = 1'b1;
            step_next = S1;
          end
          S1: begin
            qf_next   = 1'b1;
            hf_next   = 1'b1;
            step_next = S2;
          end
          S2: begin
            qf_next   = 1'b1;
            step_next = S3;
          end
          S3: begin
            if (mode5_reg) begin
              step_next = S4;
            end else begin
              qf_next   = 1'b1;
              hf_next   = 1'b1;
              irq_set   = !inhibit_reg;
              cnt_next  = '0;
              step_next = S0;
            end
          end
          default: begin
            qf_next   = 1'b1;
            hf_next   = 1'b1;
            cnt_next  = '0;
            step_next = S0;
          end
        endcase
      end
    end
  end

  // IRQ flag: inhibit-write clear beats set, set beats acknowledge.
  always_comb begin
    irq_next = irq_reg;
    if (cfg_wr && cfg_irq_inhibit) begin
      irq_next = 1'b0;
    end else if (irq_set) begin
      irq_next = 1'b1;
    end else if (irq_ack) begin
      irq_next = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_reg      <= S0;
      cnt_reg       <= '0;
      mode5_reg     <= 1'b0;
      inhibit_reg   <= 1'b0;
      pending_reg   <= 1'b0;
      p_mode5_reg   <= 1'b0;
      p_inhibit_reg <= 1'b0;
      qf_reg        <= 1'b0;
      hf_reg        <= 1'b0;
      irq_reg       <= 1'b0;
    end else begin
      step_reg      <= step_next;
      cnt_reg       <= cnt_next;
      mode5_reg     <= mode5_next;
      inhibit_reg   <= inhibit_next;
      pending_reg   <= pending_next;
      p_mode5_reg   <= p_mode5_next;
      p_inhibit_reg <= p_inhibit_next;
      qf_reg        <= qf_next;
      hf_reg        <= hf_next;
      irq_reg       <= irq_next;
    end
  end

  assign quarter_frame = qf_reg;
  assign half_frame    = hf_reg;
  assign frame_irq     = irq_reg;
  assign step          = step_reg;

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Testbench for apu_frame_sequencer: directed ce/write sequences; expected
// strobes are queued by the stimulus and matched by a separate monitor.
module tb_apu_frame_sequencer;

  localparam int T1 = 4;
  localparam int T2 = 8;
  localparam int T3 = 12;
  localparam int T4 = 16;
  localparam int T5 = 20;

  logic       clk;
  logic       reset;
  logic       ce;
  logic       cfg_wr;
  logic       cfg_mode5;
  logic       cfg_irq_inhibit;
  logic       irq_ack;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic [2:0] step;

  typedef struct {
    int e;
    bit q;
    bit h;
  } exp_t;

  exp_t sb[$];
  int   edges = 0;
  int   checks = 0;
  int   fails = 0;

  apu_frame_sequencer #(
    .STEP1(T1), .STEP2(T2), .STEP3(T3), .STEP4(T4), .STEP5(T5), .CNTW(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ce(ce),
    .cfg_wr(cfg_wr),
    .cfg_mode5(cfg_mode5),
    .cfg_irq_inhibit(cfg_irq_inhibit),
    .irq_ack(irq_ack),
    .quarter_frame(quarter_frame),
    .half_frame(half_frame),
    .frame_irq(frame_irq),
    .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edges <= edges + 1;

  // Monitor: every strobe cycle must match the queued expectation for that edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e < edges) begin
      checks++;
      fails++;
      $display("FAIL missed_strobe: no strobe observed, required q=%0d h=%0d at edge %0d", sb[0].q, sb[0].h, sb[0].e);
      void'(sb.pop_front());
    end
    if (quarter_frame === 1'b1 || half_frame === 1'b1) begin
      checks++;
      if (sb.size() > 0 && sb[0].e == edges) begin
        if (quarter_frame !== sb[0].q || half_frame !== sb[0].h) begin
          fails++;
          $display("FAIL strobe_value: edge %0d got q=%0b h=%0b, required q=%0d h=%0d", edges, quarter_frame, half_frame, sb[0].q, sb[0].h);
        end
        void'(sb.pop_front());
      end else begin
        fails++;
        $display("FAIL unexpected_strobe: edge %0d got q=%0b h=%0b, required none", edges, quarter_frame, half_frame);
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // One ce pulse followed by gap-1 idle cycles; q/h are the strobes it must cause.
  task automatic issue(input int gap, input bit q, input bit h);
    ce = 1'b1;
    if (q || h) sb.push_back('{e: edges + 1, q: q, h: h});
    @(negedge clk);
    ce = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  // 4-step schedule: c is the counter value seen by each ce.
  task automatic run4(input int gap, input int first, input int last);
    for (int c = first; c <= last; c++)
      issue(gap, (c == T1 || c == T2 || c == T3 || c == T4), (c == T2 || c == T4));
  endtask

  // 5-step schedule: nothing at T4.
  task automatic run5(input int gap, input int first, input int last);
    for (int c = first; c <= last; c++)
      issue(gap, (c == T1 || c == T2 || c == T3 || c == T5), (c == T2 || c == T5));
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    reset = 1'b1;
    ce = 1'b0;
    cfg_wr = 1'b0;
    cfg_mode5 = 1'b0;
    cfg_irq_inhibit = 1'b0;
    irq_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_qf", quarter_frame, 0);
    chk("reset_hf", half_frame, 0);
    chk("reset_irq", frame_irq, 0);
    chk("reset_step", step, 0);
    reset = 1'b0;

    // 4-step period, IRQ rises after the T4 event.
    run4(1, 0, T4 - 1);
    chk("irq_before_t4", frame_irq, 0);
    chk("step_before_t4", step, 3);
    run4(1, T4, T4);
    chk("irq_after_t4", frame_irq, 1);
    chk("step_after_wrap", step, 0);

    // Acknowledge clears the flag.
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("irq_ack_clear", frame_irq, 0);

    // Acknowledge on the same cycle as a set: set wins.
    run4(1, 0, T4 - 1);
    chk("irq_low_p2", frame_irq, 0);
    irq_ack = 1'b1;
    issue(1, 1'b1, 1'b1);
    irq_ack = 1'b0;
    chk("irq_set_beats_ack", frame_irq, 1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    chk("irq_ack_clear2", frame_irq, 0);

    // Switch to 5-step with the write landing on a ce cycle: held, then applied.
    cfg_wr = 1'b1;
    cfg_mode5 = 1'b1;
    cfg_irq_inhibit = 1'b0;
    issue(1, 1'b0, 1'b0);
    cfg_wr = 1'b0;
    issue(1, 1'b1, 1'b1);
    run5(1, 0, T4);
    chk("step_s4", step, 4);
    run5(1, T4 + 1, T5);
    chk("irq_5step_p1", frame_irq, 0);
    run5(1, 0, T5);
    chk("irq_5step_p2", frame_irq, 0);
    run5(1, 0, T5);
    chk("irq_5step_p3", frame_irq, 0);
    chk("step_5step_wrap", step, 0);

    // Sparse ce, one in seven cycles.
    run5(7, 0, T5);

    // Two writes between ce pulses: last one (4-step) wins, no immediate strobe.
    cfg_wr = 1'b1;
    cfg_mode5 = 1'b1;
    @(negedge clk);
    cfg_mode5 = 1'b0;
    @(negedge clk);
    cfg_wr = 1'b0;
    issue(7, 1'b0, 1'b0);
    run4(7, 0, T4);
    chk("irq_sparse_4step", frame_irq, 1);

    // Inhibit write clears the flag one clock later and blocks later sets.
    cfg_wr = 1'b1;
    cfg_irq_inhibit = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    chk("irq_inhibit_clear", frame_irq, 0);
    issue(1, 1'b0, 1'b0);
    run4(1, 0, T4);
    chk("irq_inhibited_p1", frame_irq, 0);
    run4(1, 0, T4);
    chk("irq_inhibited_p2", frame_irq, 0);

    // Write on the ce where cnt equals T2: that match is suppressed.
    run4(1, 0, T2 - 1);
    cfg_wr = 1'b1;
    cfg_irq_inhibit = 1'b0;
    issue(1, 1'b0, 1'b0);
    cfg_wr = 1'b0;
    issue(1, 1'b0, 1'b0);
    chk("step_after_t2_write", step, 0);
    run4(1, 0, T1);

    // Reset at cnt=10 in S2 with a pending 5-step write.
    run4(1, T1 + 1, 9);
    cfg_wr = 1'b1;
    cfg_mode5 = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
    chk("step_before_reset", step, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_qf", quarter_frame, 0);
    chk("midreset_hf", half_frame, 0);
    chk("midreset_irq", frame_irq, 0);
    chk("midreset_step", step, 0);
    issue(1, 1'b0, 1'b0);
    run4(1, 1, T4);
    chk("irq_after_reset_4step", frame_irq, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
